// File: rtl/if_stage_if.sv
//==============================================================================
// Module : if_stage_if
// Brief  : Instruction-memory request/response channel between fetch and imem.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
//==============================================================================
// Module : if_stage
// Brief  : RV32 instruction fetch stage driving the IF/ID pipeline register.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  imem,
    input  logic        d_hazard_detected,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic        if_id_valid_inst
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_drop;
    logic        r_buf_valid;
    logic [31:0] r_buf_ir;
    logic [31:0] r_buf_pc;
    logic        r_valid;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_npc;

    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_resp_live;
    logic        w_advance;
    logic [31:0] w_target;

    // Redirect target is always forced onto a word boundary.
    assign w_target    = ex_target_pc & ~32'h0000_0003;
    assign w_req_valid = rst & (r_state == S_REQ) & ~r_buf_valid & ~ex_take_branch;
    assign w_req_fire  = w_req_valid & imem.imem_req_ready;
    assign w_resp_live = (r_state == S_WAIT) & imem.imem_resp_valid & ~r_drop & ~ex_take_branch;
    assign w_advance   = ~d_hazard_detected & ~ex_take_branch;

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;

    assign if_id_IR         = r_ir;
    assign if_id_PC         = r_pc;
    assign if_id_NPC        = r_npc;
    assign if_id_valid_inst = r_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= 32'h0;
            r_drop      <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_ir    <= NOP_INST;
            r_buf_pc    <= 32'h0;
            r_valid     <= 1'b0;
            r_ir        <= NOP_INST;
            r_pc        <= 32'h0;
            r_npc       <= 32'h4;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_state    <= S_WAIT;
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    // A response always ends the wait, whether kept or discarded.
                    if (imem.imem_resp_valid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else if (ex_take_branch) begin
                        r_drop <= 1'b1;
                    end
                end
            endcase

            if (ex_take_branch) begin
                r_fetch_pc  <= w_target;
                r_buf_valid <= 1'b0;
                r_valid     <= 1'b0;
                r_ir        <= NOP_INST;
            end else if (w_advance) begin
                if (r_buf_valid) begin
                    r_buf_valid <= 1'b0;
                    r_valid     <= 1'b1;
                    r_ir        <= r_buf_ir;
                    r_pc        <= r_buf_pc;
                    r_npc       <= r_buf_pc + 32'd4;
                end else if (w_resp_live) begin
                    r_valid <= 1'b1;
                    r_ir    <= imem.imem_resp_data;
                    r_pc    <= r_req_pc;
                    r_npc   <= r_req_pc + 32'd4;
                end else begin
                    r_valid <= 1'b0;
                    r_ir    <= NOP_INST;
                end
            end else if (w_resp_live) begin
                r_buf_valid <= 1'b1;
                r_buf_ir    <= imem.imem_resp_data;
                r_buf_pc    <= r_req_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module : tb_if_stage
// Brief  : Randomized self-checking bench for if_stage against a queue-based model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_RESET = 32'h0000_0100;
    localparam logic [31:0] c_WRAP  = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hz;
    logic        br;
    logic [31:0] tgt;
    logic        zero_b;
    logic [31:0] zero_w;

    logic [31:0] ir, pc, npc;
    logic        vld;
    logic [31:0] ir_w, pc_w, npc_w;
    logic        vld_w;

    if_stage_if bus ();
    if_stage_if bus_w ();

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(c_RESET), .NOP_INST(c_NOP)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .imem              (bus),
        .d_hazard_detected (hz),
        .ex_take_branch    (br),
        .ex_target_pc      (tgt),
        .if_id_IR          (ir),
        .if_id_PC          (pc),
        .if_id_NPC         (npc),
        .if_id_valid_inst  (vld)
    );

    if_stage #(.RESET_PC(c_WRAP), .NOP_INST(c_NOP)) u_dut_wrap (
        .clk               (clk),
        .rst               (rst),
        .imem              (bus_w),
        .d_hazard_detected (zero_b),
        .ex_take_branch    (zero_b),
        .ex_target_pc      (zero_w),
        .if_id_IR          (ir_w),
        .if_id_PC          (pc_w),
        .if_id_NPC         (npc_w),
        .if_id_valid_inst  (vld_w)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one in-flight fetch slot, a queue of held responses,
    // and the architectural view of IF/ID.
    logic [31:0] m_fetch;
    bit          m_inflight;
    logic [31:0] m_inf_pc;
    bit          m_dead;
    ent_t        m_held[$];
    bit          m_valid;
    logic [31:0] m_ir;
    logic [31:0] m_pc;

    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    bit          wm_busy;
    logic [31:0] wm_addr;
    logic [31:0] wq[$];
    bit          w_got;
    logic [31:0] w_ir, w_pc, w_npc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_fetch    = c_RESET;
        m_inflight = 1'b0;
        m_dead     = 1'b0;
        m_held.delete();
        m_valid    = 1'b0;
        m_ir       = c_NOP;
        m_pc       = 32'h0;
        mem_busy   = 1'b0;
        wm_busy    = 1'b0;
    endtask

    task automatic step(input bit r, input int hz_pct, input int br_pct,
                        input int rdy_pct, input int lat_max);
        bit          rv;
        logic [31:0] rd;
        bit          rdy;
        bit          req_exp;
        bit          fire;
        bit          resp_here;
        bit          live;
        ent_t        got;
        ent_t        e;

        @(negedge clk);
        rst = r;
        hz  = ($urandom_range(0, 99) < hz_pct);
        br  = ($urandom_range(0, 99) < br_pct);
        if ($urandom_range(0, 7) == 0)
            tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else
            tgt = 32'h0000_0200 + ($urandom & 32'h3FF);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        bus.imem_req_ready = rdy;

        rv = 1'b0;
        rd = $urandom;
        if (r && mem_busy) begin
            if (mem_cnt <= 1) begin
                rv       = 1'b1;
                rd       = memf(mem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rd;

        bus_w.imem_req_ready  = 1'b1;
        bus_w.imem_resp_valid = r && wm_busy;
        bus_w.imem_resp_data  = memf(wm_addr);
        wm_busy = 1'b0;

        #1;
        req_exp = r && !m_inflight && (m_held.size() == 0) && !br;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(req_exp));
        if (req_exp)
            chk("req_addr", bus.imem_req_addr, m_fetch);
        chk("ifid_valid", 32'(vld), 32'(m_valid));
        chk("ifid_ir", ir, m_ir);
        chk("ifid_pc", pc, m_pc);
        chk("ifid_npc", npc, m_pc + 32'd4);

        fire = bus.imem_req_valid && rdy;

        if (r && bus_w.imem_req_valid) begin
            if (wq.size() < 4) wq.push_back(bus_w.imem_req_addr);
            wm_busy = 1'b1;
            wm_addr = bus_w.imem_req_addr;
        end
        if (vld_w && !w_got) begin
            w_got = 1'b1;
            w_ir  = ir_w;
            w_pc  = pc_w;
            w_npc = npc_w;
        end

        if (!r) begin
            model_reset();
        end else begin
            resp_here = m_inflight && rv;
            live      = resp_here && !m_dead && !br;
            got.ir    = rd;
            got.pc    = m_inf_pc;
            if (br && m_inflight && !rv) m_dead = 1'b1;
            if (resp_here) begin
                m_inflight = 1'b0;
                m_dead     = 1'b0;
            end
            if (br) begin
                m_valid = 1'b0;
                m_ir    = c_NOP;
                m_held.delete();
                m_fetch = tgt & ~32'h3;
            end else if (!hz) begin
                if (m_held.size() != 0) begin
                    e       = m_held.pop_front();
                    m_valid = 1'b1;
                    m_ir    = e.ir;
                    m_pc    = e.pc;
                end else if (live) begin
                    m_valid = 1'b1;
                    m_ir    = got.ir;
                    m_pc    = got.pc;
                end else begin
                    m_valid = 1'b0;
                    m_ir    = c_NOP;
                end
            end else if (live) begin
                m_held.push_back(got);
            end
            if (req_exp && rdy) begin
                m_inflight = 1'b1;
                m_inf_pc   = m_fetch;
                m_dead     = 1'b0;
                m_fetch    = m_fetch + 32'd4;
            end
            if (fire) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, lat_max);
                mem_addr = bus.imem_req_addr;
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        hz     = 1'b0;
        br     = 1'b0;
        tgt    = 32'h0;
        zero_b = 1'b0;
        zero_w = 32'h0;
        w_got  = 1'b0;
        w_ir   = 32'h0;
        w_pc   = 32'h0;
        w_npc  = 32'h0;
        wm_addr = 32'h0;
        bus.imem_req_ready    = 1'b0;
        bus.imem_resp_valid   = 1'b0;
        bus.imem_resp_data    = 32'h0;
        bus_w.imem_req_ready  = 1'b0;
        bus_w.imem_resp_valid = 1'b0;
        bus_w.imem_resp_data  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);

        step(1'b0, 0, 0, 100, 1);
        repeat (12) step(1'b1, 0, 0, 100, 1);

        chk("wrap_req0", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, c_WRAP);
        chk("wrap_req1", (wq.size() > 1) ? wq[1] : 32'hDEAD_BEEF, 32'h0000_0000);
        chk("wrap_got", 32'(w_got), 32'd1);
        chk("wrap_pc", w_pc, c_WRAP);
        chk("wrap_npc", w_npc, 32'h0000_0000);
        chk("wrap_ir", w_ir, memf(c_WRAP));

        repeat (40)   step(1'b1, 0, 0, 30, 2);
        repeat (300)  step(1'b1, 40, 0, 80, 3);
        repeat (500)  step(1'b1, 20, 10, 70, 3);
        repeat (2)    step(1'b0, 20, 10, 70, 3);
        repeat (1200) step(1'b1, 25, 8, 70, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
